leaf_out_packetizer: RTL and testbench
======================================

LEAF_OUT_PACKETIZER -- requirements
Module: leaf_out_packetizer

Interface
REQ-001 Parameters SHALL be: PACKET_BITS 49, packet width; PAYLOAD_BITS 32, user word width; NUM_LEAF_BITS 5, destination leaf field; NUM_PORT_BITS 4, destination port field; NUM_ADDR_BITS 7, receiver write-address field; NUM_OUT_PORTS 4, user output channels (1..16); CREDIT_INIT 128, per-channel receiver free space after reset.
REQ-002 clk input 1: single clock; one clock only; reset is synchronous and active-high.
REQ-003 reset input 1: synchronous, active-high.
REQ-004 din_leaf_user2interface input NUM_OUT_PORTS*PAYLOAD_BITS: channel i occupies slice [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-005 vld_user2interface input NUM_OUT_PORTS: per-channel word valid.
REQ-006 ack_interface2user output NUM_OUT_PORTS: one-cycle word-accepted pulse per channel.
REQ-007 dout_leaf_interface2bft output PACKET_BITS: registered packet to the BFT.
REQ-008 bft_ready input 1: the BFT accepts the held packet this cycle.
REQ-009 resend input 1: suppress output and freeze arbitration.
REQ-010 cfg_wr input 1, cfg_idx input NUM_PORT_BITS, cfg_dest_leaf input NUM_LEAF_BITS, cfg_dest_port input NUM_PORT_BITS: destination-table write.
REQ-011 credit_vld input 1, credit_idx input NUM_PORT_BITS, credit_amt input NUM_ADDR_BITS+1: receiver free-space return.

Function
REQ-012 Packet layout SHALL be: bit PACKET_BITS-1 = valid; then dest_leaf; then dest_port; then addr; then payload in bits [PAYLOAD_BITS-1:0]; the field widths SHALL sum to PACKET_BITS.
REQ-013 A channel is eligible when vld=1 and its credit > 0.
REQ-014 Arbitration SHALL be round-robin: search starts at the channel after the last granted channel; after reset it starts at channel 0.
REQ-015 The load condition is (!out_valid || bft_ready) && !resend; at most one grant per cycle, and only when the load condition holds.
REQ-016 On a grant to channel i: ack[i]=1 in the same cycle (combinational); the packet is registered on that edge; packet latency is 1 cycle.
REQ-017 A user holds vld and data until it receives ack; vld deasserted before ack SHALL be ignored without error.
REQ-018 Per-channel addr counter SHALL increment by 1 on each grant and wrap modulo 2^NUM_ADDR_BITS (127->0).
REQ-019 Per-channel credit counter SHALL be NUM_ADDR_BITS+1 bits wide, decrement by 1 on grant, and increase by credit_amt on credit_vld.
REQ-020 Simultaneous grant and credit return on the same channel SHALL apply the net value credit+amt-1.
REQ-021 Credit SHALL saturate at CREDIT_INIT.
REQ-022 credit_idx or cfg_idx >= NUM_OUT_PORTS SHALL be ignored.
REQ-023 bft_ready=1 with no new grant SHALL clear out_valid; the output then equals all zeros.
REQ-024 While resend=1: dout_leaf_interface2bft=0 combinationally, no grants occur, and all counters and registers hold.
REQ-025 cfg_wr takes effect for grants from the next cycle; a same-cycle grant uses the old entry.

Reset
REQ-026 On reset: dout register=0, out_valid=0, ack=0, addr counters=0, credits=CREDIT_INIT, RR pointer=0, destination table=0.
REQ-027 Reset mid-transfer SHALL drop the held packet; a word not yet acked is not consumed.

Structure
REQ-028 The packet field widths/offsets and a pack function SHALL live in shared package leaf_pkg.
REQ-029 Round-robin arbiter SHALL be sub-module rr_arbiter (request vector, enable, one-hot grant, pointer).

Verification
REQ-030 After reset, ch0 vld with payload 0xDEADBEEF, table[0]={leaf 3, port 2}, bft_ready=1 -> ack0 in the grant cycle; next cycle packet = valid 1, leaf 3, port 2, addr 0, payload 0xDEADBEEF.
REQ-031 All 4 channels held valid, bft_ready=1 -> grant order 0,1,2,3,0, one packet per cycle.
REQ-032 CREDIT_INIT=2, ch1 sends 2 words -> third word gets no ack; credit_vld idx1 amt1 -> word sent the next cycle.
REQ-033 130 words on ch0 -> addr sequence 0..127,0,1.
REQ-034 bft_ready=0 with a held packet -> output stable and no ack; resend=1 -> output 0, and after release the packet reappears unchanged.
REQ-035 Credit return of 5 on a channel at CREDIT_INIT-2 -> credit = CREDIT_INIT; a grant in the same cycle -> CREDIT_INIT-1.

Source files
------------

// File: rtl/leaf_pkg.sv
// Shared packet layout for the leaf output path: field widths, bit offsets and the packer.
package leaf_pkg;

    localparam int unsigned PKT_PAYLOAD_W = 32;
    localparam int unsigned PKT_ADDR_W    = 7;
    localparam int unsigned PKT_PORT_W    = 4;
    localparam int unsigned PKT_LEAF_W    = 5;
    localparam int unsigned PKT_W         = 1 + PKT_LEAF_W + PKT_PORT_W + PKT_ADDR_W + PKT_PAYLOAD_W;

    localparam int unsigned PKT_PAYLOAD_LSB = 0;
    localparam int unsigned PKT_ADDR_LSB    = PKT_PAYLOAD_LSB + PKT_PAYLOAD_W;
    localparam int unsigned PKT_PORT_LSB    = PKT_ADDR_LSB + PKT_ADDR_W;
    localparam int unsigned PKT_LEAF_LSB    = PKT_PORT_LSB + PKT_PORT_W;
    localparam int unsigned PKT_VALID_BIT   = PKT_LEAF_LSB + PKT_LEAF_W;

    // MSB-first field order matches the bit offsets above
    typedef struct packed {
        logic                     valid;
        logic [PKT_LEAF_W-1:0]    dest_leaf;
        logic [PKT_PORT_W-1:0]    dest_port;
        logic [PKT_ADDR_W-1:0]    addr;
        logic [PKT_PAYLOAD_W-1:0] payload;
    } packet_t;

    function automatic packet_t pack_packet(
        input logic [PKT_LEAF_W-1:0]    dest_leaf,
        input logic [PKT_PORT_W-1:0]    dest_port,
        input logic [PKT_ADDR_W-1:0]    addr,
        input logic [PKT_PAYLOAD_W-1:0] payload
    );
        packet_t pkt;
        pkt.valid     = 1'b1;
        pkt.dest_leaf = dest_leaf;
        pkt.dest_port = dest_port;
        pkt.addr      = addr;
        pkt.payload   = payload;
        return pkt;
    endfunction

endpackage

// File: rtl/leaf_out_packetizer_rr_arbiter.sv
// Round-robin arbiter: search begins one past the last grant; pointer starts at 0.
module rr_arbiter
    import leaf_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     i_req,
    input  logic             i_en,
    output logic [N-1:0]     o_gnt_c,
    output logic [IDX_W-1:0] o_gnt_idx_c
);

    localparam int unsigned POS_W = IDX_W + 1;

    logic [IDX_W-1:0] r_ptr;
    logic [POS_W-1:0] w_pos;
    logic             w_found;

    // First requester at or after the pointer, wrapping modulo N
    always_comb begin
        o_gnt_c     = '0;
        o_gnt_idx_c = '0;
        w_found     = 1'b0;
        w_pos       = '0;
        if (i_en) begin
            for (int k = 0; k < int'(N); k++) begin
                w_pos = POS_W'(r_ptr) + POS_W'(k);
                if (w_pos >= POS_W'(N)) begin
                    w_pos = w_pos - POS_W'(N);
                end
                if (!w_found && i_req[w_pos[IDX_W-1:0]]) begin
                    w_found                      = 1'b1;
                    o_gnt_c[w_pos[IDX_W-1:0]]    = 1'b1;
                    o_gnt_idx_c                  = w_pos[IDX_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (o_gnt_idx_c == IDX_W'(N - 1)) ? '0 : o_gnt_idx_c + IDX_W'(1);
        end
    end

endmodule

// File: rtl/leaf_out_packetizer.sv
// Packs per-channel user words into BFT packets with per-channel destination,
// write address and receiver credit tracking; one packet register toward the BFT.
module leaf_out_packetizer
    import leaf_pkg::*;
#(
    parameter int unsigned PACKET_BITS   = PKT_W,
    parameter int unsigned PAYLOAD_BITS  = PKT_PAYLOAD_W,
    parameter int unsigned NUM_LEAF_BITS = PKT_LEAF_W,
    parameter int unsigned NUM_PORT_BITS = PKT_PORT_W,
    parameter int unsigned NUM_ADDR_BITS = PKT_ADDR_W,
    parameter int unsigned NUM_OUT_PORTS = 4,
    parameter int unsigned CREDIT_INIT   = 128
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
    output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
    input  logic                                  bft_ready,
    input  logic                                  resend,
    input  logic                                  cfg_wr,
    input  logic [NUM_PORT_BITS-1:0]              cfg_idx,
    input  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]              cfg_dest_port,
    input  logic                                  credit_vld,
    input  logic [NUM_PORT_BITS-1:0]              credit_idx,
    input  logic [NUM_ADDR_BITS:0]                credit_amt
);

    localparam int unsigned N      = NUM_OUT_PORTS;
    localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CRED_W = NUM_ADDR_BITS + 1;
    localparam int unsigned SUM_W  = CRED_W + 2;

    logic [NUM_ADDR_BITS-1:0] r_addr      [N];
    logic [CRED_W-1:0]        r_credit    [N];
    logic [NUM_LEAF_BITS-1:0] r_dest_leaf [N];
    logic [NUM_PORT_BITS-1:0] r_dest_port [N];
    logic [PACKET_BITS-1:0]   r_dout;
    logic                     r_out_valid;

    logic [N-1:0]             w_req;
    logic [N-1:0]             w_gnt;
    logic [IDX_W-1:0]         w_gnt_idx;
    logic                     w_any_gnt;
    logic                     w_load;
    logic [PAYLOAD_BITS-1:0]  w_sel_payload;
    packet_t                  w_pkt_s;
    logic [PACKET_BITS-1:0]   w_pkt;
    logic [CRED_W-1:0]        w_credit_nxt [N];
    logic [SUM_W-1:0]         w_sum;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            w_req[i] = vld_user2interface[i] && (r_credit[i] != '0);
        end
    end

    // A new packet may enter the register when it is empty or being drained
    assign w_load = (!r_out_valid || bft_ready) && !resend;

    rr_arbiter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_req       (w_req),
        .i_en        (w_load && !reset),
        .o_gnt_c     (w_gnt),
        .o_gnt_idx_c (w_gnt_idx)
    );

    assign w_any_gnt          = |w_gnt;
    assign ack_interface2user = w_gnt;

    assign w_sel_payload = din_leaf_user2interface[w_gnt_idx*PAYLOAD_BITS +: PAYLOAD_BITS];
    assign w_pkt_s = pack_packet(PKT_LEAF_W'(r_dest_leaf[w_gnt_idx]),
                                 PKT_PORT_W'(r_dest_port[w_gnt_idx]),
                                 PKT_ADDR_W'(r_addr[w_gnt_idx]),
                                 PKT_PAYLOAD_W'(w_sel_payload));
    assign w_pkt   = PACKET_BITS'(w_pkt_s);

    // Returned credit saturates at the receiver depth before this cycle's grant is charged
    always_comb begin
        w_credit_nxt = '{default: '0};
        w_sum        = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_sum = SUM_W'(r_credit[i]);
            if (credit_vld && (credit_idx == NUM_PORT_BITS'(i))) begin
                w_sum = w_sum + SUM_W'(credit_amt);
            end
            if (w_sum > SUM_W'(CREDIT_INIT)) begin
                w_sum = SUM_W'(CREDIT_INIT);
            end
            if (w_gnt[i]) begin
                w_sum = w_sum - SUM_W'(1);
            end
            w_credit_nxt[i] = w_sum[CRED_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout      <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                r_addr[i]      <= '0;
                r_credit[i]    <= CRED_W'(CREDIT_INIT);
                r_dest_leaf[i] <= '0;
                r_dest_port[i] <= '0;
            end
        end else if (!resend) begin
            if (w_any_gnt) begin
                r_dout              <= w_pkt;
                r_out_valid         <= 1'b1;
                r_addr[w_gnt_idx]   <= r_addr[w_gnt_idx] + NUM_ADDR_BITS'(1);
            end else if (w_load) begin
                r_dout      <= '0;
                r_out_valid <= 1'b0;
            end
            for (int i = 0; i < int'(N); i++) begin
                r_credit[i] <= w_credit_nxt[i];
                // Out-of-range indices match no channel and are dropped
                if (cfg_wr && (cfg_idx == NUM_PORT_BITS'(i))) begin
                    r_dest_leaf[i] <= cfg_dest_leaf;
                    r_dest_port[i] <= cfg_dest_port;
                end
            end
        end
    end

    assign dout_leaf_interface2bft = resend ? '0 : r_dout;

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Scoreboard bench for leaf_out_packetizer: a per-cycle behavioural model predicts acks
// and queues expected packets; an independent monitor checks what the BFT side sees.
module tb_leaf_out_packetizer;

    localparam int N    = 4;
    localparam int PB   = 32;
    localparam int INIT = 128;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*PB-1:0] din;
    logic [N-1:0]    vld;
    logic [N-1:0]    ack;
    logic [48:0]     dout;
    logic            bft_ready;
    logic            resend;
    logic            cfg_wr;
    logic [3:0]      cfg_idx;
    logic [4:0]      cfg_dest_leaf;
    logic [3:0]      cfg_dest_port;
    logic            credit_vld;
    logic [3:0]      credit_idx;
    logic [7:0]      credit_amt;

    always #5 clk = ~clk;

    leaf_out_packetizer #(.CREDIT_INIT(INIT)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .dout_leaf_interface2bft (dout),
        .bft_ready               (bft_ready),
        .resend                  (resend),
        .cfg_wr                  (cfg_wr),
        .cfg_idx                 (cfg_idx),
        .cfg_dest_leaf           (cfg_dest_leaf),
        .cfg_dest_port           (cfg_dest_port),
        .credit_vld              (credit_vld),
        .credit_idx              (credit_idx),
        .credit_amt              (credit_amt)
    );

    int checks = 0;
    int passes = 0;

    // Reference model state
    int          m_credit [N];
    int          m_addr   [N];
    int          m_leaf   [N];
    int          m_port   [N];
    int          m_last;
    bit          m_valid;
    logic [48:0] exp_q [$];
    logic [31:0] word [N];
    bit          mon_exp_valid = 1'b0;

    // Side-band requests for the next step
    bit         n_cfg_wr = 0;
    logic [3:0] n_cfg_idx = '0;
    logic [4:0] n_leaf = '0;
    logic [3:0] n_port = '0;
    bit         n_cv = 0;
    logic [3:0] n_ci = '0;
    logic [7:0] n_ca = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_last  = N - 1;
        for (int c = 0; c < N; c++) begin
            m_credit[c] = INIT;
            m_addr[c]   = 0;
            m_leaf[c]   = 0;
            m_port[c]   = 0;
        end
        exp_q.delete();
    endtask

    // One clock: drive at negedge, check the combinational ack, advance the model
    task automatic step(input logic [N-1:0] mask, input bit rdy, input bit rs, input bit rst);
        int          g;
        bit          load;
        logic [N-1:0] ea;
        @(negedge clk);
        reset      = rst;
        bft_ready  = rdy;
        resend     = rs;
        vld        = mask;
        for (int i = 0; i < N; i++) din[i*PB +: PB] = word[i];
        cfg_wr        = n_cfg_wr;
        cfg_idx       = n_cfg_idx;
        cfg_dest_leaf = n_leaf;
        cfg_dest_port = n_port;
        credit_vld    = n_cv;
        credit_idx    = n_ci;
        credit_amt    = n_ca;
        n_cfg_wr = 0;
        n_cv     = 0;
        mon_exp_valid = m_valid && !rs;
        #1;
        g    = -1;
        load = (!m_valid || rdy) && !rs;
        if (!rst && load) begin
            for (int k = 1; k <= N; k++) begin
                int ch;
                ch = (m_last + k) % N;
                if (g < 0 && mask[ch] && m_credit[ch] > 0) g = ch;
            end
        end
        ea = '0;
        if (g >= 0) ea[g] = 1'b1;
        check("ack", 64'(ack), 64'(ea));
        if (rst) begin
            model_reset();
        end else if (!rs) begin
            if (g >= 0) begin
                exp_q.push_back({1'b1, 5'(m_leaf[g]), 4'(m_port[g]), 7'(m_addr[g]), word[g]});
                m_valid   = 1'b1;
                m_addr[g] = (m_addr[g] + 1) % 128;
                m_last    = g;
            end else if (load) begin
                m_valid = 1'b0;
            end
            for (int c = 0; c < N; c++) begin
                int v;
                v = m_credit[c];
                if (credit_vld && int'(credit_idx) == c) v = v + int'(credit_amt);
                if (v > INIT) v = INIT;
                if (g == c) v = v - 1;
                m_credit[c] = v;
                if (cfg_wr && int'(cfg_idx) == c) begin
                    m_leaf[c] = int'(cfg_dest_leaf);
                    m_port[c] = int'(cfg_dest_port);
                end
            end
        end
        if (g >= 0) word[g] = $urandom;
    endtask

    task automatic cfg(input int idx, input int leaf, input int port);
        n_cfg_wr  = 1;
        n_cfg_idx = 4'(idx);
        n_leaf    = 5'(leaf);
        n_port    = 4'(port);
        step('0, 1, 0, 0);
    endtask

    // Monitor: just before each active edge, check what the BFT sees
    initial begin
        logic [48:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (reset === 1'b0) begin
                check("valid_bit", 64'(dout[48]), 64'(mon_exp_valid));
                if (!dout[48]) begin
                    check("idle_zero", 64'(dout), 64'd0);
                end else if (bft_ready && !resend) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pkt", 64'(dout), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("packet", 64'(dout), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [48:0] held;
        logic [N-1:0] mask;
        int cnt;
        reset = 1'b1; din = '0; vld = '0; bft_ready = 1'b0; resend = 1'b0;
        cfg_wr = 1'b0; cfg_idx = '0; cfg_dest_leaf = '0; cfg_dest_port = '0;
        credit_vld = 1'b0; credit_idx = '0; credit_amt = '0;
        for (int i = 0; i < N; i++) word[i] = $urandom;
        model_reset();

        // Reset state and a single packet
        step('0, 1, 0, 1);
        step('0, 1, 0, 1);
        step('0, 1, 0, 0);
        check("reset_dout", 64'(dout), 64'd0);
        check("reset_ack", 64'(ack), 64'd0);
        cfg(0, 3, 2);
        word[0] = 32'hDEADBEEF;
        step(4'b0001, 1, 0, 0);
        check("first_ack", 64'(ack), 64'd1);
        step('0, 1, 0, 0);
        check("first_pkt", 64'(dout), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}));

        // Round robin across all channels from reset
        step('0, 1, 0, 1);
        for (int c = 0; c < N; c++) cfg(c, c + 1, 3 - c);
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 1, 0, 0);
            check("rr_order", 64'(ack), 64'(1) << (k % 4));
        end

        // Credit exhaustion on channel 1, then single-credit release
        for (int n = 0; n < 200 && m_credit[1] > 0; n++) step(4'b0010, 1, 0, 0);
        step(4'b0010, 1, 0, 0);
        check("no_credit_blocked", 64'(ack), 64'd0);
        n_cv = 1; n_ci = 4'd1; n_ca = 8'd1;
        step(4'b0010, 1, 0, 0);
        check("credit_same_cycle", 64'(ack), 64'd0);
        step(4'b0010, 1, 0, 0);
        check("credit_released", 64'(ack), 64'b0010);

        // Saturating return at CREDIT_INIT-2 with a simultaneous grant leaves CREDIT_INIT-1
        n_cv = 1; n_ci = 4'd1; n_ca = 8'(INIT - 2);
        step('0, 1, 0, 0);
        n_cv = 1; n_ci = 4'd1; n_ca = 8'd5;
        step(4'b0010, 1, 0, 0);
        cnt = 0;
        for (int n = 0; n < INIT + 5; n++) begin
            step(4'b0010, 1, 0, 0);
            if (ack[1]) cnt++;
        end
        check("sat_then_grant", 64'(cnt), 64'(INIT - 1));

        // Address wrap over 130 words with a credit back each cycle
        step('0, 1, 0, 1);
        cfg(0, 7, 5);
        for (int k = 0; k <= 130; k++) begin
            if (k < 130) begin
                n_cv = 1; n_ci = 4'd0; n_ca = 8'd1;
            end
            step((k < 130) ? 4'b0001 : 4'b0000, 1, 0, 0);
            if (k > 0) check("addr_seq", 64'(dout[38:32]), 64'((k - 1) % 128));
        end

        // Backpressure holds the packet; resend blanks it without losing it
        step(4'b0001, 1, 0, 0);
        step(4'b0011, 0, 0, 0);
        held = dout;
        check("held_valid", 64'(held[48]), 64'd1);
        for (int k = 0; k < 3; k++) begin
            step(4'b0011, 0, 0, 0);
            check("held_stable", 64'(dout), 64'(held));
        end
        for (int k = 0; k < 3; k++) begin
            step(4'b0011, 0, 1, 0);
            check("resend_zero", 64'(dout), 64'd0);
        end
        step(4'b0011, 1, 0, 0);
        check("resend_reappear", 64'(dout), 64'(held));

        // Randomized traffic
        mask = '0;
        for (int n = 0; n < 3000; n++) begin
            bit rs, rst;
            for (int c = 0; c < N; c++) begin
                if (!mask[c]) mask[c] = ($urandom % 3) == 0;
                else if (($urandom % 40) == 0) mask[c] = 1'b0;
            end
            rs  = ($urandom % 25) == 0;
            rst = ($urandom % 800) == 0;
            if (!rs && ($urandom % 10) == 0) begin
                n_cfg_wr  = 1;
                n_cfg_idx = 4'($urandom % 16);
                n_leaf    = 5'($urandom);
                n_port    = 4'($urandom);
            end
            if (!rs && ($urandom % 3) == 0) begin
                n_cv = 1;
                n_ci = 4'($urandom % 6);
                n_ca = (($urandom % 20) == 0) ? 8'($urandom) : 8'($urandom % 8);
            end
            step(mask, ($urandom % 4) != 0, rs, rst);
        end

        for (int k = 0; k < 10; k++) step('0, 1, 0, 0);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
